stream_arbiter_rr: RTL
======================

STREAM_ARBITER_RR -- requirements
Module: stream_arbiter_rr

Interface
REQ-001 Parameter NUM_INPUTS, default 4, number of requester ports (2..16).
REQ-002 Parameter DATA_WIDTH, default 32, payload width per beat.
REQ-003 Parameter ID_WIDTH, default 2, width of the grant index; SHALL equal clog2(NUM_INPUTS), minimum 1.
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  NUM_INPUTS*DATA_WIDTH  packed payloads; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 in_last  input  NUM_INPUTS  per-port end-of-packet flag.
REQ-008 in_valid  input  NUM_INPUTS  per-port valid.
REQ-009 in_ready  output  NUM_INPUTS  per-port ready.
REQ-010 out_data  output  DATA_WIDTH  registered payload.
REQ-011 out_last  output  1  registered end-of-packet.
REQ-012 out_id  output  ID_WIDTH  registered source port of the current out beat.
REQ-013 out_valid  output  1  registered valid.
REQ-014 out_ready  input  1  downstream ready.

Function
REQ-015 Handshake rule: a beat transfers on any edge where valid && ready; once asserted, out_valid SHALL NOT drop and out_data/out_last/out_id SHALL stay stable until transfer.
REQ-016 FSM states: IDLE (no grant) and LOCKED (grant held by port g).
REQ-017 IDLE: all in_ready = 0; if any in_valid = 1, pick the winner by round-robin, load g, and enter LOCKED on the next edge; otherwise stay in IDLE.
REQ-018 Round-robin: search starts at index (ptr+1) mod NUM_INPUTS and wraps; the first port with in_valid = 1 wins.
REQ-019 LOCKED: in_ready[g] = (!out_valid || out_ready); all other in_ready bits = 0.
REQ-020 Accepting a beat from port g loads out_data/out_last from port g, sets out_id = g and sets out_valid = 1 on the next edge (latency 1 cycle).
REQ-021 If out_valid && out_ready and no new beat is accepted, out_valid SHALL clear on the next edge.
REQ-022 Simultaneous out transfer and in accept SHALL replace the out register with no bubble; sustained throughput inside a packet is 1 beat/cycle.
REQ-023 Accepting a beat with in_last = 1: next state IDLE and ptr <= g. Packets are never interleaved.
REQ-024 Between packets there is exactly one arbitration cycle (the IDLE cycle) with no input accepted; the out register may still drain during that cycle.
REQ-025 A granted port dropping in_valid mid-packet SHALL keep the lock, with no timeout.
REQ-026 in_valid deasserting on non-granted ports SHALL have no effect; the grant is not re-evaluated while LOCKED.
REQ-027 NUM_INPUTS not a power of two: the pointer wraps at NUM_INPUTS-1, and indices >= NUM_INPUTS are never granted.
REQ-028 Invariants: at most one in_ready bit set; in_ready = 0 in IDLE; out_id is always < NUM_INPUTS.

Reset
REQ-029 While reset = 1, on the edge: state = IDLE, out_valid = 0, ptr = NUM_INPUTS-1 (port 0 has first priority), g = 0.
REQ-030 All in_ready SHALL be 0 during reset and during the first cycle after reset deasserts (registered past_reset gate).
REQ-031 out_data, out_last and out_id are not reset; their values are don't-care while out_valid = 0.
REQ-032 Reset mid-packet discards the lock and any held out beat; no beat is emitted afterwards until a new arbitration.

Verification
REQ-033 Single port 2 sends a 3-beat packet (A,B,C, last on C) with out_ready = 1 -> out beats A,B,C with out_id = 2 on consecutive cycles; first beat appears 2 cycles after in_valid rises (arbitration + register).
REQ-034 All 4 ports continuously send 1-beat packets -> grant order 0,1,2,3,0,... with one idle cycle between packets.
REQ-035 Ports 0 and 1 both valid, port 0 sends a 4-beat packet while port 1 holds valid -> port 1 is granted only after port 0's last beat, with no interleaving.
REQ-036 out_ready toggles 1,0,0,1 during a packet -> no beat is lost or duplicated, out_data is held during stalls, and in_ready[g] tracks (!out_valid || out_ready).
REQ-037 Reset asserted for 1 cycle mid-packet -> out_valid = 0 and in_ready = 0 for that cycle plus the next; the next grant goes to the lowest-index valid port.
REQ-038 Formal: prove REQ-028, the stability rule in REQ-015, and per-port in-order delivery of an arbitrary tracked beat.

Source files
------------

// File: rtl/stream_arbiter_rr.sv
// stream_arbiter_rr: round-robin packet arbiter, N valid/ready streams into one.
// A port keeps the grant from its first beat through its last beat, so packets
// are never interleaved. One IDLE cycle is spent arbitrating between packets.
// The output stage is a single register that accepts a new beat in the same
// cycle it hands one downstream, so a locked packet moves at 1 beat/cycle.
module stream_arbiter_rr #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_last,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_last,
  output logic [ID_WIDTH-1:0]              out_id,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]            r_state;
  logic [ID_WIDTH-1:0]   r_ptr;        // last port that finished a packet
  logic [ID_WIDTH-1:0]   r_g;          // port holding the grant
  logic                  r_past_reset; // low for the first cycle out of reset
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_last;
  logic [ID_WIDTH-1:0]   r_out_id;

  logic                  w_any;
  logic [ID_WIDTH-1:0]   w_win;
  logic [ID_WIDTH-1:0]   w_idx;
  logic                  w_grant_ok;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_last;

  // Round-robin winner: scan from ptr+1 with wrap; iterating from the far end
  // down lets the nearest valid port overwrite any farther candidate.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = NUM_INPUTS; k >= 1; k--) begin
      w_idx = ID_WIDTH'((int'(r_ptr) + k) % NUM_INPUTS);
      if (in_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // Payload mux for the granted port (constant slices only).
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (r_g == ID_WIDTH'(i)) begin
        w_sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_last = in_last[i];
      end
    end
  end

  // The granted port may push when the out register is empty or draining now;
  // reset and the first post-reset cycle hold every ready low.
  assign w_grant_ok = (r_state == S_LOCKED) && r_past_reset && !reset &&
                      (!r_out_valid || out_ready);
  assign w_accept   = w_grant_ok && in_valid[r_g];

  // One-hot ready toward the lock owner only.
  always_comb begin
    in_ready = '0;
    if (w_grant_ok) in_ready[r_g] = 1'b1;
  end

  // Grant FSM, rotation pointer and output-valid tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= ID_WIDTH'(NUM_INPUTS - 1);
      r_g          <= '0;
      r_past_reset <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_past_reset <= 1'b1;
      if (w_accept)                       r_out_valid <= 1'b1;
      else if (r_out_valid && out_ready)  r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_g     <= w_win;
            r_state <= S_LOCKED;
          end
        end
        default: begin
          if (w_accept && w_sel_last) begin
            r_state <= S_IDLE;
            r_ptr   <= r_g;
          end
        end
      endcase
    end
  end

  // Output payload register; contents only matter while out_valid is high.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_out_data <= w_sel_data;
      r_out_last <= w_sel_last;
      r_out_id   <= r_g;
    end
  end

  // A beat still held when reset arrives is dropped at once, not presented.
  assign out_valid = r_out_valid && !reset;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_id    = r_out_id;

endmodule
